// File: rtl/dk_peak_detect_nch.sv
// N-channel baseline-corrected peak detector: pulse_out 2 ce-samples after din; result held after a window of cfg_stretch+1 samples.
// Backpressure: peak_valid holds until peak_ready; triggers arriving while a result is pending are dropped and flagged.
module dk_peak_detect_nch #(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int TW       = 14,
  parameter int SW       = 8,
  parameter int BL_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [SW-1:0]     cfg_stretch,
  input  logic [TW-1:0]     cfg_threshold,
  input  logic              cfg_offset_en,
  input  logic              cfg_offset_rst,
  input  logic              cfg_sim,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH*DW-1:0] pulse_out,
  output logic              pulse_valid,
  output logic [NCH*DW-1:0] peak_out,
  output logic              peak_pileup,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic              peak_dropped
);

  localparam int AW = DW + BL_SHIFT;

  typedef enum logic [1:0] {IDLE, STRETCH, OUT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      sim_cnt_q, sim_cnt_d;
  logic            v1_q, v1_d;
  logic            pulse_valid_q, pulse_valid_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            pile_q, pile_d;
  logic            peak_pileup_q, peak_pileup_d;
  logic            peak_valid_q, peak_valid_d;
  logic            peak_dropped_q, peak_dropped_d;
  logic [NCH-1:0]  above_prev_q, above_prev_d;

  logic [DW-1:0]   x_q [NCH], x_d [NCH];
  logic [DW-1:0]   pulse_q [NCH], pulse_d [NCH];
  logic [AW-1:0]   acc_q [NCH], acc_d [NCH];
  logic [DW-1:0]   pk_q [NCH], pk_d [NCH];
  logic [DW-1:0]   peak_q [NCH], peak_d [NCH];

  logic [DW-1:0]   sim_val;
  logic [DW-1:0]   sat_pulse [NCH];
  logic [AW-1:0]   acc_upd [NCH];
  logic [DW-1:0]   pk_max [NCH];
  logic [NCH-1:0]  above;
  logic [NCH-1:0]  rise;
  logic            any_above;
  logic            trig;
  logic [DW:0]     thr_ext;

  // Triangle test pulse: ramp up over 64 samples, down over 64, then 128 samples of zero.
  always_comb begin
    sim_val = '0;
    if (!sim_cnt_q[7]) begin
      sim_val = DW'({(sim_cnt_q[6] ? ~sim_cnt_q[5:0] : sim_cnt_q[5:0]), 6'd0});
    end
  end

  always_comb begin
    thr_ext = {1'b0, {(DW-TW){1'b0}}, cfg_threshold};
    for (int i = 0; i < NCH; i++) begin
      logic [DW-1:0] bl;
      logic [DW:0]   diff;
      bl   = acc_q[i][AW-1:BL_SHIFT];
      diff = $signed({x_q[i][DW-1], x_q[i]}) - $signed({bl[DW-1], bl});
      if (diff[DW] != diff[DW-1]) begin
        sat_pulse[i] = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
        sat_pulse[i] = diff[DW-1:0];
      end
      acc_upd[i] = acc_q[i] + {{BL_SHIFT{x_q[i][DW-1]}}, x_q[i]} - {{BL_SHIFT{bl[DW-1]}}, bl};
      above[i]   = $signed({pulse_q[i][DW-1], pulse_q[i]}) > $signed(thr_ext);
      rise[i]    = above[i] & ~above_prev_q[i];
      pk_max[i]  = ($signed(pulse_q[i]) > $signed(pk_q[i])) ? pulse_q[i] : pk_q[i];
    end
    any_above = |above;
    trig      = any_above & ~(|above_prev_q);
  end

  always_comb begin
    state_d        = state_q;
    sim_cnt_d      = sim_cnt_q;
    v1_d           = v1_q;
    pulse_valid_d  = 1'b0;
    cnt_d          = cnt_q;
    pile_d         = pile_q;
    peak_pileup_d  = peak_pileup_q;
    peak_valid_d   = peak_valid_q;
    peak_dropped_d = 1'b0;
    above_prev_d   = above_prev_q;
    for (int i = 0; i < NCH; i++) begin
      x_d[i]     = x_q[i];
      pulse_d[i] = pulse_q[i];
      acc_d[i]   = acc_q[i];
      pk_d[i]    = pk_q[i];
      peak_d[i]  = peak_q[i];
    end

    if (ce) begin
      sim_cnt_d     = sim_cnt_q + 8'd1;
      v1_d          = 1'b1;
      pulse_valid_d = v1_q;
      above_prev_d  = above;
      for (int i = 0; i < NCH; i++) begin
        x_d[i]     = cfg_sim ? sim_val : din[i*DW +: DW];
        pulse_d[i] = cfg_offset_en ? sat_pulse[i] : x_q[i];
        // Baseline only follows quiet samples so pulses do not pull it up.
        if (cfg_offset_en && (state_q == IDLE) && !any_above) begin
          acc_d[i] = acc_upd[i];
        end
      end

      case (state_q)
        IDLE: begin
          if (trig) begin
            pile_d = 1'b0;
            for (int i = 0; i < NCH; i++) pk_d[i] = pulse_q[i];
            if (cfg_stretch == '0) begin
              for (int i = 0; i < NCH; i++) peak_d[i] = pulse_q[i];
              peak_pileup_d = 1'b0;
              peak_valid_d  = 1'b1;
              state_d       = OUT;
            end else begin
              cnt_d   = cfg_stretch - SW'(1);
              state_d = STRETCH;
            end
          end
        end
        STRETCH: begin
          for (int i = 0; i < NCH; i++) pk_d[i] = pk_max[i];
          if (|rise) pile_d = 1'b1;
          if (cnt_q == '0) begin
            for (int i = 0; i < NCH; i++) peak_d[i] = pk_max[i];
            peak_pileup_d = pile_q | (|rise);
            peak_valid_d  = 1'b1;
            state_d       = OUT;
          end else begin
            cnt_d = cnt_q - SW'(1);
          end
        end
        OUT: begin
          if (trig) peak_dropped_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    if (cfg_offset_rst) begin
      for (int i = 0; i < NCH; i++) acc_d[i] = '0;
    end

    // Handshake is evaluated every clk, independent of ce.
    if ((state_q == OUT) && peak_valid_q && peak_ready) begin
      peak_valid_d = 1'b0;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sim_cnt_q      <= '0;
      v1_q           <= 1'b0;
      pulse_valid_q  <= 1'b0;
      cnt_q          <= '0;
      pile_q         <= 1'b0;
      peak_pileup_q  <= 1'b0;
      peak_valid_q   <= 1'b0;
      peak_dropped_q <= 1'b0;
      above_prev_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        x_q[i]     <= '0;
        pulse_q[i] <= '0;
        acc_q[i]   <= '0;
        pk_q[i]    <= '0;
        peak_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      sim_cnt_q      <= sim_cnt_d;
      v1_q           <= v1_d;
      pulse_valid_q  <= pulse_valid_d;
      cnt_q          <= cnt_d;
      pile_q         <= pile_d;
      peak_pileup_q  <= peak_pileup_d;
      peak_valid_q   <= peak_valid_d;
      peak_dropped_q <= peak_dropped_d;
      above_prev_q   <= above_prev_d;
      for (int i = 0; i < NCH; i++) begin
        x_q[i]     <= x_d[i];
        pulse_q[i] <= pulse_d[i];
        acc_q[i]   <= acc_d[i];
        pk_q[i]    <= pk_d[i];
        peak_q[i]  <= peak_d[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign pulse_out[g*DW +: DW] = pulse_q[g];
    assign peak_out[g*DW +: DW]  = peak_q[g];
  end

  assign pulse_valid  = pulse_valid_q;
  assign peak_pileup  = peak_pileup_q;
  assign peak_valid   = peak_valid_q;
  assign peak_dropped = peak_dropped_q;

endmodule

// File: tb/tb_dk_peak_detect_nch.sv
// Bench for dk_peak_detect_nch: directed scenarios plus randomized traffic, all checked each clk
// against a sample-level behavioural model.
module tb_dk_peak_detect_nch;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [7:0]  cfg_stretch;
  logic [13:0] cfg_threshold;
  logic        cfg_offset_en;
  logic        cfg_offset_rst;
  logic        cfg_sim;
  logic [63:0] din;
  logic [63:0] pulse_out;
  logic        pulse_valid;
  logic [63:0] peak_out;
  logic        peak_pileup;
  logic        peak_valid;
  logic        peak_ready;
  logic        peak_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  dk_peak_detect_nch dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .cfg_stretch(cfg_stretch), .cfg_threshold(cfg_threshold),
    .cfg_offset_en(cfg_offset_en), .cfg_offset_rst(cfg_offset_rst), .cfg_sim(cfg_sim),
    .din(din), .pulse_out(pulse_out), .pulse_valid(pulse_valid),
    .peak_out(peak_out), .peak_pileup(peak_pileup), .peak_valid(peak_valid),
    .peak_ready(peak_ready), .peak_dropped(peak_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, in plain integers.
  longint m_x [4], m_pulse [4], m_acc [4], m_pk [4], m_res [4];
  bit     m_prev [4];
  int     m_s, m_wlen, m_wpos;
  bit     m_v1, m_pvld, m_inwin, m_pend, m_pile, m_rpile, m_drop;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint lane(input logic [63:0] v, input int c);
    logic [15:0] w;
    w = v[c*16 +: 16];
    return longint'($signed(w));
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint sim_value(input int s);
    if (s < 64) return s * 64;
    if (s < 128) return (127 - s) * 64;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_x[c] = 0; m_pulse[c] = 0; m_acc[c] = 0; m_pk[c] = 0; m_res[c] = 0; m_prev[c] = 0;
    end
    m_s = 0; m_wlen = 0; m_wpos = 0;
    m_v1 = 0; m_pvld = 0; m_inwin = 0; m_pend = 0; m_pile = 0; m_rpile = 0; m_drop = 0;
  endtask

  // One clock edge of the reference, using the inputs currently driven.
  task automatic model_step();
    longint npulse [4], nx [4], bl;
    bit     ab [4];
    bit     any_ab, any_prev, rise_any, trig, pend_old, busy_old;
    pend_old = m_pend;
    busy_old = m_inwin;
    m_drop   = 0;
    if (ce) begin
      any_ab = 0; any_prev = 0; rise_any = 0;
      for (int c = 0; c < 4; c++) begin
        ab[c] = m_pulse[c] > longint'(cfg_threshold);
        any_ab |= ab[c];
        any_prev |= m_prev[c];
        if (ab[c] && !m_prev[c]) rise_any = 1;
      end
      trig = any_ab && !any_prev;
      if (pend_old) begin
        if (trig) m_drop = 1;
      end else begin
        if (!busy_old && trig) begin
          m_inwin = 1; m_wlen = int'(cfg_stretch) + 1; m_wpos = 0; m_pile = 0;
          for (int c = 0; c < 4; c++) m_pk[c] = m_pulse[c];
        end else if (busy_old) begin
          for (int c = 0; c < 4; c++) if (m_pulse[c] > m_pk[c]) m_pk[c] = m_pulse[c];
          if (rise_any) m_pile = 1;
        end
        if (m_inwin) begin
          m_wpos++;
          if (m_wpos == m_wlen) begin
            m_inwin = 0; m_pend = 1; m_rpile = m_pile;
            for (int c = 0; c < 4; c++) m_res[c] = m_pk[c];
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        bl = m_acc[c] >>> 4;
        npulse[c] = cfg_offset_en ? sat16(m_x[c] - bl) : m_x[c];
        if (cfg_offset_en && !busy_old && !pend_old && !any_ab) m_acc[c] += m_x[c] - bl;
        nx[c] = cfg_sim ? sim_value(m_s) : lane(din, c);
        m_prev[c] = ab[c];
      end
      for (int c = 0; c < 4; c++) begin
        m_pulse[c] = npulse[c];
        m_x[c] = nx[c];
      end
      m_s = (m_s + 1) % 256;
      m_pvld = m_v1;
      m_v1 = 1;
    end else begin
      m_pvld = 0;
    end
    if (cfg_offset_rst) for (int c = 0; c < 4; c++) m_acc[c] = 0;
    if (pend_old && peak_ready) m_pend = 0;
  endtask

  task automatic compare_all();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("pulse_out[%0d]", c), lane(pulse_out, c), m_pulse[c]);
      chk($sformatf("peak_out[%0d]", c), lane(peak_out, c), m_res[c]);
    end
    chk("pulse_valid", longint'(pulse_valid), longint'(m_pvld));
    chk("peak_valid", longint'(peak_valid), longint'(m_pend));
    chk("peak_pileup", longint'(peak_pileup), longint'(m_rpile));
    chk("peak_dropped", longint'(peak_dropped), longint'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic set_all(input int v);
    for (int c = 0; c < 4; c++) din[c*16 +: 16] = 16'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int cnt;
  bit pv_prev;
  longint v;

  initial begin
    rst_n = 1'b0; ce = 1'b0; cfg_stretch = '0; cfg_threshold = 14'd1000;
    cfg_offset_en = 1'b0; cfg_offset_rst = 1'b0; cfg_sim = 1'b0; din = '0; peak_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pulse_valid", longint'(pulse_valid), 0);
    chk("rst_peak_valid", longint'(peak_valid), 0);
    chk("rst_pulse_out0", lane(pulse_out, 0), 0);
    rst_n = 1'b1;

    // Reset asserted mid-window discards the event.
    ce = 1'b1; cfg_stretch = 8'd50;
    din[15:0] = 16'd2000; tick();
    din = '0;
    for (int k = 0; k < 10; k++) tick();
    @(posedge clk);
    model_step();
    #3 rst_n = 1'b0;
    #1 model_reset();
    chk("arst_peak_valid", longint'(peak_valid), 0);
    chk("arst_pulse_valid", longint'(pulse_valid), 0);
    chk("arst_pulse_out0", lane(pulse_out, 0), 0);
    chk("arst_peak_out0", lane(peak_out, 0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (peak_valid) cnt++;
    end
    chk("no_result_after_rst", cnt, 0);

    // Internal triangle source: one 4032 peak per 256 samples.
    do_reset();
    cfg_sim = 1'b1; cfg_stretch = 8'd99; cfg_threshold = 14'd1000; peak_ready = 1'b1;
    cnt = 0; pv_prev = 0;
    for (int k = 0; k < 1024; k++) begin
      tick();
      if (peak_valid && !pv_prev) begin
        cnt++;
        for (int c = 0; c < 4; c++) chk($sformatf("sim_peak[%0d]", c), lane(peak_out, c), 4032);
        chk("sim_pileup", longint'(peak_pileup), 0);
      end
      pv_prev = peak_valid;
    end
    chk("sim_result_count", cnt, 4);
    cfg_sim = 1'b0;

    // Baseline tracking of a constant input, then clear.
    do_reset();
    cfg_offset_en = 1'b1; cfg_threshold = 14'd16383; set_all(500);
    for (int k = 0; k < 200; k++) tick();
    for (int c = 0; c < 4; c++) begin
      v = lane(pulse_out, c);
      chk($sformatf("bl_settle[%0d]", c), longint'(v >= -1 && v <= 1), 1);
    end
    ce = 1'b0; cfg_offset_rst = 1'b1; tick();
    cfg_offset_rst = 1'b0; ce = 1'b1; tick();
    chk("bl_clear_pulse", lane(pulse_out, 0), 500);

    // Pile-up on ch2 inside a 21-sample window.
    do_reset();
    cfg_offset_en = 1'b0; cfg_threshold = 14'd1000; cfg_stretch = 8'd20; din = '0;
    for (int k = 0; k < 8; k++) begin
      int seq [8] = '{0, 0, 3000, 3000, 0, 0, 2500, 0};
      din[47:32] = 16'(seq[k]);
      tick();
    end
    din = '0;
    for (int k = 0; k < 30; k++) tick();
    chk("pile_peak_ch2", lane(peak_out, 2), 3000);
    chk("pile_flag", longint'(peak_pileup), 1);

    // Backpressure: second trigger while a result is pending is dropped.
    peak_ready = 1'b0; cfg_stretch = 8'd3;
    din[15:0] = 16'd2000; tick();
    din = '0;
    for (int k = 0; k < 10; k++) tick();
    cnt = 0;
    din[15:0] = 16'd2500; tick();
    din = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (peak_dropped) cnt++;
    end
    chk("drop_count", cnt, 1);
    chk("bp_peak_hold", lane(peak_out, 0), 2000);
    chk("bp_valid_held", longint'(peak_valid), 1);
    peak_ready = 1'b1; tick();
    chk("bp_released", longint'(peak_valid), 0);

    // Saturation at both rails, with ce gaps in the pipeline.
    do_reset();
    cfg_offset_en = 1'b1; cfg_threshold = 14'd16383; set_all(100);
    for (int k = 0; k < 200; k++) tick();
    din[15:0] = 16'h8000; tick();
    set_all(100); ce = 1'b0; tick(); tick();
    ce = 1'b1; tick();
    chk("sat_neg", lane(pulse_out, 0), -32768);
    ce = 1'b0; tick();
    chk("sat_neg_hold", lane(pulse_out, 0), -32768);
    ce = 1'b1; cfg_offset_rst = 1'b1; tick();
    cfg_offset_rst = 1'b0; set_all(-100);
    for (int k = 0; k < 200; k++) tick();
    din[15:0] = 16'h7fff; tick();
    set_all(-100); ce = 1'b0; tick();
    ce = 1'b1; tick();
    chk("sat_pos", lane(pulse_out, 0), 32767);

    // Randomized traffic against the model.
    for (int blk = 0; blk < 30; blk++) begin
      cfg_stretch   = 8'($urandom_range(0, 15));
      cfg_threshold = 14'($urandom_range(800, 3000));
      cfg_offset_en = 1'($urandom_range(0, 1));
      cfg_sim       = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < 120; k++) begin
        for (int c = 0; c < 4; c++) begin
          int r, x;
          r = $urandom_range(0, 99);
          if (r < 85) x = int'($urandom_range(0, 200)) - 100;
          else if (r < 95) x = int'($urandom_range(500, 8000));
          else x = int'($urandom_range(0, 65535)) - 32768;
          din[c*16 +: 16] = 16'(x);
        end
        ce             = ($urandom_range(0, 9) < 8);
        peak_ready     = ($urandom_range(0, 9) < 7);
        cfg_offset_rst = ($urandom_range(0, 99) == 0);
        if (k == 60) cfg_stretch = 8'($urandom_range(0, 15));
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
